lcd_bus_ctrl: RTL and testbench
===============================

Name: lcd_bus_ctrl

Overview:
HD44780 16x2 bus-timing engine that sits directly downstream of the LCD content sequencer. It accepts one command or data byte per handshake and drives LCD_RS/LCD_DATA/LCD_EN with the required setup, pulse-width, hold and execution-wait timing, then signals completion. The content sequencer no longer counts delays; it only issues bytes and waits for oDONE/oREADY.

Parameters:
SETUP_CYC, 4, iCLK cycles with RS/DATA stable and EN low before EN rises (>=40 ns at 50 MHz)
EN_HIGH_CYC, 25, iCLK cycles EN is held high (>=450 ns)
HOLD_CYC, 2, iCLK cycles with RS/DATA held and EN low after EN falls
CMD_WAIT_CYC, 2000, execution wait for normal command/data bytes (40 us)
CLR_WAIT_CYC, 82000, execution wait for clear (0x01) and home (0x02/0x03) commands (1.64 ms)

Ports:
iCLK  in  1  system clock (CLOCK_50 at top level)
iRST  in  1  synchronous active-high reset
iDATA  in  8  byte to send
iRS  in  1  0 = command, 1 = data
iSTART  in  1  request; accepted only on a cycle where oREADY=1
oREADY  out  1  engine idle, able to accept iSTART
oDONE  out  1  one-cycle pulse when the byte's execution wait has elapsed
LCD_DATA  out  8  LCD data bus (write-only; top-level inout driven from this)
LCD_RS  out  1  LCD register select
LCD_RW  out  1  constant 0 (write only)
LCD_EN  out  1  LCD enable strobe

Behaviour:
- Single clock iCLK; iRST synchronous, active-high; all outputs registered.
- Reset values: state IDLE, oREADY=1, oDONE=0, LCD_EN=0, LCD_RS=0, LCD_DATA=8'h00, LCD_RW=0, counter=0.
- FSM: IDLE -> SETUP -> PULSE -> HOLD -> WAIT -> IDLE. A single down-counter is loaded on each transition. Counter width is $clog2 of the largest parameter plus 1.
- IDLE: oREADY=1. On an edge where iSTART=1, latch iDATA/iRS into LCD_DATA/LCD_RS, clear oREADY and go to SETUP. Call this cycle 0.
- Long wait is selected when the latched iRS=0 and iDATA is 8'h01, 8'h02 or 8'h03. All other bytes use CMD_WAIT_CYC.
- Timing relative to cycle 0, with S=SETUP_CYC, E=EN_HIGH_CYC, H=HOLD_CYC, W=selected wait:
  - LCD_RS and LCD_DATA are valid from cycle 1.
  - LCD_EN=1 for cycles S+1 through S+E inclusive.
  - HOLD covers cycles S+E+1 through S+E+H.
  - WAIT covers the next W cycles.
  - oDONE=1 for exactly one cycle, cycle S+E+H+W+1. The FSM returns to IDLE on that same cycle, so oREADY=1 from then on.
- Back-to-back transfers: iSTART asserted in the oDONE cycle is accepted, because oREADY is already 1. The next transfer's cycle 0 is the oDONE cycle.
- LCD_RS and LCD_DATA hold their last value in IDLE. They change only when a new byte is accepted.
- iSTART while oREADY=0 is ignored and not queued. Changes on iDATA/iRS while busy have no effect.
- Reset mid-operation: on the next edge LCD_EN=0, state=IDLE, oREADY=1, no oDONE pulse. This applies even if EN was high.
- Every parameter must be >=1. Elaboration fails on a 0 value via a generate-time check.
- LCD_RW is tied 0 at all times.

Decomposition:
- Shared package lcd_pkg holds:
  - State enum: IDLE, SETUP, PULSE, HOLD, WAIT.
  - Command constants: LCD_CLEAR=8'h01, LCD_HOME=8'h02, LCD_FUNC_8B2L=8'h38, LCD_DISP_ON=8'h0C, LCD_ENTRY_INC=8'h06, LCD_LINE1=8'h80, LCD_LINE2=8'hC0.
  - Default timing parameters for 50 MHz.
- No sub-module. The single down-counter stays inline.

Test Plan:
- Reset, then idle 10 cycles -> oREADY=1, LCD_EN=0, LCD_RW=0, oDONE=0 throughout.
- iSTART, iRS=1, iDATA=8'h41 (defaults) -> LCD_RS=1 and LCD_DATA=8'h41 from cycle 1; LCD_EN high exactly cycles 5..29; oDONE single pulse at cycle 2032; oREADY=1 from cycle 2032.
- iSTART, iRS=0, iDATA=8'h01 -> LCD_EN cycles 5..29; oDONE at cycle 82032. Repeat with 8'h38 -> oDONE at cycle 2032.
- iSTART held high continuously with bytes 8'h38, 8'h0C, 8'h06 -> exactly three EN pulses, one per oDONE. Extra iSTART cycles while busy produce no pulse. LCD_DATA changes only in the cycle after acceptance.
- Assert iRST for one cycle at cycle 15 (EN high) -> LCD_EN=0 and oREADY=1 on the next edge; no oDONE pulse. A new iSTART afterwards completes normally.
- Run with SETUP_CYC=1, EN_HIGH_CYC=1, HOLD_CYC=1, CMD_WAIT_CYC=1 -> EN high only at cycle 2; oDONE at cycle 5.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 bus-timing engine: FSM state type,
// common command bytes and default 50 MHz timing.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    WAIT  = 3'd4
  } lcd_state_t;

  // HD44780 command bytes used by the content sequencer
  localparam logic [7:0] LCD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_HOME      = 8'h02;
  localparam logic [7:0] LCD_FUNC_8B2L = 8'h38;
  localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_ENTRY_INC = 8'h06;
  localparam logic [7:0] LCD_LINE1     = 8'h80;
  localparam logic [7:0] LCD_LINE2     = 8'hC0;

  // Default timing in clock cycles at 50 MHz
  localparam int DEF_SETUP_CYC    = 4;      // >= 40 ns
  localparam int DEF_EN_HIGH_CYC  = 25;     // >= 450 ns
  localparam int DEF_HOLD_CYC     = 2;
  localparam int DEF_CMD_WAIT_CYC = 2000;   // 40 us
  localparam int DEF_CLR_WAIT_CYC = 82000;  // 1.64 ms

  // Clear and return-home need the long execution wait; 0x03 decodes as home.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return (!rs) && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_bus_ctrl.sv
// HD44780 bus-timing engine. Accepts one command/data byte per handshake and
// generates RS/DATA setup, EN pulse, hold and the execution wait, then pulses
// oDONE on the cycle it returns to idle.
//
// state | meaning
// IDLE  | oREADY=1, RS/DATA hold last byte, waiting for iSTART
// SETUP | RS/DATA driven, EN low, SETUP_CYC cycles
// PULSE | EN high, EN_HIGH_CYC cycles
// HOLD  | EN low, RS/DATA held, HOLD_CYC cycles
// WAIT  | LCD executing; CMD_WAIT_CYC or CLR_WAIT_CYC cycles
module lcd_bus_ctrl
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC    = DEF_SETUP_CYC,
  parameter int EN_HIGH_CYC  = DEF_EN_HIGH_CYC,
  parameter int HOLD_CYC     = DEF_HOLD_CYC,
  parameter int CMD_WAIT_CYC = DEF_CMD_WAIT_CYC,
  parameter int CLR_WAIT_CYC = DEF_CLR_WAIT_CYC
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [7:0] iDATA,
  input  logic       iRS,
  input  logic       iSTART,
  output logic       oREADY,
  output logic       oDONE,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN
);

  localparam int MAX_CYC = max_of(max_of(max_of(SETUP_CYC, EN_HIGH_CYC),
                                         max_of(HOLD_CYC, CMD_WAIT_CYC)),
                                  CLR_WAIT_CYC);
  localparam int CW      = $clog2(MAX_CYC) + 1;

  // The counter is loaded with N-1 so a phase lasts exactly N cycles,
  // leaving on the cycle the counter reads zero.
  localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_PULSE = CW'(EN_HIGH_CYC - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] LD_CMD   = CW'(CMD_WAIT_CYC - 1);
  localparam logic [CW-1:0] LD_CLR   = CW'(CLR_WAIT_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if ((SETUP_CYC < 1) || (EN_HIGH_CYC < 1) || (HOLD_CYC < 1) ||
      (CMD_WAIT_CYC < 1) || (CLR_WAIT_CYC < 1)) begin : g_param_check
    $error("lcd_bus_ctrl: every timing parameter must be >= 1");
  end

  lcd_state_t    r_state;
  lcd_state_t    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_ready;
  logic          r_done;
  logic          r_en;
  logic          r_rs;
  logic [7:0]    r_data;

  logic          w_ready_nxt;
  logic          w_done_nxt;
  logic          w_en_nxt;
  logic          w_rs_nxt;
  logic [7:0]    w_data_nxt;
  logic          w_cnt_zero;
  logic          w_accept;
  logic [CW-1:0] w_ld_wait;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_accept   = (r_state == IDLE) && iSTART;
  // Wait length follows the byte already latched on the bus, not the live inputs
  assign w_ld_wait  = is_long_cmd(r_rs, r_data) ? LD_CLR : LD_CMD;

  // State register plus registered outputs; reset also abandons a transfer mid-pulse
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_en    <= 1'b0;
      r_rs    <= 1'b0;
      r_data  <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_ready_nxt;
      r_done  <= w_done_nxt;
      r_en    <= w_en_nxt;
      r_rs    <= w_rs_nxt;
      r_data  <= w_data_nxt;
    end
  end

  // Next state and down-counter: count to zero, then reload for the next phase
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_zero ? r_cnt : (r_cnt - CNT_ONE);
    case (r_state)
      IDLE: begin
        if (iSTART) begin
          w_state_nxt = SETUP;
          w_cnt_nxt   = LD_SETUP;
        end
      end
      SETUP: begin
        if (w_cnt_zero) begin
          w_state_nxt = PULSE;
          w_cnt_nxt   = LD_PULSE;
        end
      end
      PULSE: begin
        if (w_cnt_zero) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = LD_HOLD;
        end
      end
      HOLD: begin
        if (w_cnt_zero) begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = w_ld_wait;
        end
      end
      WAIT: begin
        if (w_cnt_zero) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a flop
  always_comb begin
    w_ready_nxt = (w_state_nxt == IDLE);
    w_en_nxt    = (w_state_nxt == PULSE);
    w_done_nxt  = (r_state == WAIT) && w_cnt_zero;
    w_rs_nxt    = r_rs;
    w_data_nxt  = r_data;
    if (w_accept) begin
      w_rs_nxt   = iRS;
      w_data_nxt = iDATA;
    end
  end

  assign oREADY   = r_ready;
  assign oDONE    = r_done;
  assign LCD_EN   = r_en;
  assign LCD_RS   = r_rs;
  assign LCD_DATA = r_data;
  assign LCD_RW   = 1'b0;

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Bench for lcd_bus_ctrl: three instances (default timing, short timing for
// randomized traffic, all-ones timing) each compared cycle by cycle against
// a transfer-level reference model.
module tb_lcd_bus_ctrl;

  localparam int P_S [3] = '{4, 3, 1};
  localparam int P_E [3] = '{25, 5, 1};
  localparam int P_H [3] = '{2, 2, 1};
  localparam int P_W [3] = '{2000, 20, 1};
  localparam int P_C [3] = '{82000, 60, 1};

  logic       clk = 1'b0;
  logic       rst      [3];
  logic       start    [3];
  logic       rs_in    [3];
  logic [7:0] data_in  [3];
  logic       ready    [3];
  logic       done     [3];
  logic [7:0] lcd_data [3];
  logic       lcd_rs   [3];
  logic       lcd_rw   [3];
  logic       lcd_en   [3];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one record of the transfer in flight per instance
  bit         m_act  [3];
  longint     m_c0   [3];
  longint     m_done [3];
  bit         m_rs   [3];
  bit [7:0]   m_data [3];
  longint     cyc    [3];
  bit         prev_en  [3];
  int         en_rise  [3];
  int         done_cnt [3];

  always #10 clk = ~clk;

  lcd_bus_ctrl u_dut_def (
    .iCLK(clk), .iRST(rst[0]), .iDATA(data_in[0]), .iRS(rs_in[0]), .iSTART(start[0]),
    .oREADY(ready[0]), .oDONE(done[0]), .LCD_DATA(lcd_data[0]), .LCD_RS(lcd_rs[0]),
    .LCD_RW(lcd_rw[0]), .LCD_EN(lcd_en[0])
  );

  lcd_bus_ctrl #(
    .SETUP_CYC(3), .EN_HIGH_CYC(5), .HOLD_CYC(2), .CMD_WAIT_CYC(20), .CLR_WAIT_CYC(60)
  ) u_dut_short (
    .iCLK(clk), .iRST(rst[1]), .iDATA(data_in[1]), .iRS(rs_in[1]), .iSTART(start[1]),
    .oREADY(ready[1]), .oDONE(done[1]), .LCD_DATA(lcd_data[1]), .LCD_RS(lcd_rs[1]),
    .LCD_RW(lcd_rw[1]), .LCD_EN(lcd_en[1])
  );

  lcd_bus_ctrl #(
    .SETUP_CYC(1), .EN_HIGH_CYC(1), .HOLD_CYC(1), .CMD_WAIT_CYC(1), .CLR_WAIT_CYC(1)
  ) u_dut_min (
    .iCLK(clk), .iRST(rst[2]), .iDATA(data_in[2]), .iRS(rs_in[2]), .iSTART(start[2]),
    .oREADY(ready[2]), .oDONE(done[2]), .LCD_DATA(lcd_data[2]), .LCD_RS(lcd_rs[2]),
    .LCD_RW(lcd_rw[2]), .LCD_EN(lcd_en[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int wait_len(input int id, input bit rs, input bit [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? P_C[id] : P_W[id];
  endfunction

  function automatic bit m_ready(input int id);
    return !(m_act[id] && cyc[id] > m_c0[id] && cyc[id] < m_done[id]);
  endfunction

  // Compare this cycle, drive inputs for this cycle, advance one clock
  task automatic step(input int id, input bit st, input bit rs_i, input bit [7:0] d_i,
                      input bit rst_i);
    logic [12:0] obs, exp;
    bit          rdy, en_e, dn_e;
    longint      rel;
    rdy  = m_ready(id);
    rel  = cyc[id] - m_c0[id];
    en_e = m_act[id] && rel >= P_S[id] + 1 && rel <= P_S[id] + P_E[id];
    dn_e = m_act[id] && cyc[id] == m_done[id];
    exp  = {rdy, dn_e, en_e, m_rs[id], 1'b0, m_data[id]};
    obs  = {ready[id], done[id], lcd_en[id], lcd_rs[id], lcd_rw[id], lcd_data[id]};
    check($sformatf("bus[%0d] cyc=%0d {rdy,done,en,rs,rw,data}", id, cyc[id]),
          32'(obs), 32'(exp));
    if (lcd_en[id] === 1'b1 && !prev_en[id]) en_rise[id]++;
    prev_en[id] = (lcd_en[id] === 1'b1);
    if (done[id] === 1'b1) done_cnt[id]++;

    rst[id]     = rst_i;
    start[id]   = st;
    rs_in[id]   = rs_i;
    data_in[id] = d_i;
    if (rst_i) begin
      m_act[id]  = 1'b0;
      m_rs[id]   = 1'b0;
      m_data[id] = 8'h00;
    end else if (rdy && st) begin
      m_act[id]  = 1'b1;
      m_c0[id]   = cyc[id];
      m_done[id] = cyc[id] + P_S[id] + P_E[id] + P_H[id] + wait_len(id, rs_i, d_i) + 1;
      m_rs[id]   = rs_i;
      m_data[id] = d_i;
    end
    @(posedge clk);
    cyc[id]++;
    @(negedge clk);
  endtask

  task automatic idle(input int id, input int n);
    for (int i = 0; i < n; i++) step(id, 1'b0, 1'($urandom), 8'($urandom), 1'b0);
  endtask

  // One transfer, then run until the model is ready again (that cycle is oDONE)
  task automatic send(input int id, input bit rs_i, input bit [7:0] d_i, input bit junk);
    int n;
    step(id, 1'b1, rs_i, d_i, 1'b0);
    n = 0;
    while (!m_ready(id) && n < 90000) begin
      step(id, junk ? 1'($urandom) : 1'b0, 1'($urandom), 8'($urandom), 1'b0);
      n++;
    end
  endtask

  task automatic do_reset(input int id);
    rst[id] = 1'b1; start[id] = 1'b0; rs_in[id] = 1'b0; data_in[id] = 8'h00;
    @(posedge clk);
    @(negedge clk);
    cyc[id] = 0; m_act[id] = 1'b0; m_rs[id] = 1'b0; m_data[id] = 8'h00;
    m_c0[id] = 0; m_done[id] = 0; prev_en[id] = 1'b0;
    rst[id] = 1'b0;
  endtask

  task automatic run_def();
    int d0;
    do_reset(0);
    idle(0, 10);
    send(0, 1'b1, 8'h41, 1'b0);
    send(0, 1'b0, 8'h01, 1'b0);
    send(0, 1'b0, 8'h38, 1'b0);
    idle(0, 2);
    check("done_pulses_def", 32'(done_cnt[0]), 32'd3);
    check("en_pulses_def", 32'(en_rise[0]), 32'd3);
    // Reset at cycle 15 of a transfer, while EN is high
    step(0, 1'b1, 1'b0, 8'h38, 1'b0);
    idle(0, 14);
    check("en_high_before_rst", 32'(lcd_en[0]), 32'd1);
    d0 = done_cnt[0];
    step(0, 1'b0, 1'b0, 8'h00, 1'b1);
    check("en_after_rst", 32'(lcd_en[0]), 32'd0);
    check("ready_after_rst", 32'(ready[0]), 32'd1);
    idle(0, 3);
    send(0, 1'b1, 8'h41, 1'b1);
    idle(0, 3);
    check("done_after_rst_restart", 32'(done_cnt[0] - d0), 32'd1);
  endtask

  task automatic run_short();
    bit [7:0] seq [3];
    int k, n, e0, d0, len;
    bit rdy, r;
    bit [7:0] d;
    seq[0] = 8'h38; seq[1] = 8'h0C; seq[2] = 8'h06;
    do_reset(1);
    idle(1, 3);
    // iSTART held high across three transfers
    e0 = en_rise[1]; d0 = done_cnt[1];
    k = 0; n = 0;
    while (k < 3 && n < 1000) begin
      rdy = m_ready(1);
      step(1, 1'b1, 1'b0, seq[k], 1'b0);
      if (rdy) k++;
      n++;
    end
    n = 0;
    while (!m_ready(1) && n < 1000) begin
      step(1, 1'b0, 1'b0, 8'h00, 1'b0);
      n++;
    end
    idle(1, 2);
    check("held_start_en_pulses", 32'(en_rise[1] - e0), 32'd3);
    check("held_start_done_pulses", 32'(done_cnt[1] - d0), 32'd3);
    // Random traffic, including long-wait bytes and back-to-back starts
    for (int t = 0; t < 60; t++) begin
      r = 1'($urandom);
      d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      send(1, r, d, 1'b1);
      idle(1, $urandom_range(0, 2));
    end
    // Resets landing at random points in a transfer
    for (int t = 0; t < 8; t++) begin
      r = 1'($urandom);
      d = 8'($urandom_range(0, 3));
      len = P_S[1] + P_E[1] + P_H[1] + wait_len(1, r, d);
      step(1, 1'b1, r, d, 1'b0);
      idle(1, $urandom_range(0, len - 1));
      step(1, 1'b0, 1'b0, 8'h00, 1'b1);
      idle(1, 2);
    end
    send(1, 1'b1, 8'h5A, 1'b0);
    idle(1, 2);
  endtask

  task automatic run_min();
    do_reset(2);
    idle(2, 2);
    send(2, 1'b1, 8'h41, 1'b0);
    send(2, 1'b0, 8'h01, 1'b0);
    send(2, 1'b0, 8'h38, 1'b1);
    idle(2, 3);
    check("min_done_pulses", 32'(done_cnt[2]), 32'd3);
    check("min_en_pulses", 32'(en_rise[2]), 32'd3);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      en_rise[i] = 0; done_cnt[i] = 0;
      rst[i] = 1'b1; start[i] = 1'b0; rs_in[i] = 1'b0; data_in[i] = 8'h00;
    end
    @(negedge clk);
    fork
      run_def();
      run_short();
      run_min();
    join
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
